// File: rtl/frame_arb_pkg.sv
// Shared state codes and constants for the frame source arbiter.
package frame_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_STREAM    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } arb_state_t;

  localparam logic [3:0] FRM_IDLE = 4'b0000;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority encoder: first set request at or after ptr, wrapping.
// Purely combinational; any=0 leaves idx at 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan downwards so the lowest rotated offset is the last (winning) assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NREQ]) begin
        idx = IW'((int'(ptr) + i) % NREQ);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_src_arbiter.sv
// Round-robin share of one frame processor among NREQ sources: grant, header VALID,
// TX_ACK-triggered pop of LEN words, wait for processor Idle, then an enforced gap.
module frame_src_arbiter
  import frame_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int LEN_W   = 12,
  parameter int GAP     = 8,
  parameter int ACK_TMO = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         REQ,
  input  logic [NREQ*LEN_W-1:0]   LEN,
  output logic [NREQ-1:0]         GNT,
  output logic [$clog2(NREQ)-1:0] MUX_SEL,
  output logic                    RD_EN,
  output logic                    VALID,
  input  logic                    TX_ACK,
  input  logic [3:0]              FRM_STATE,
  output logic                    BUSY,
  output logic                    TMO_ERR,
  output logic [2:0]              ARB_STATE
);

  localparam int SW = $clog2(NREQ);
  localparam int TW = $clog2(ACK_TMO + 1);
  localparam int GW = $clog2(GAP + 1);

  arb_state_t       r_state, w_state;
  logic [NREQ-1:0]  r_gnt, w_gnt;
  logic [SW-1:0]    r_sel, w_sel;
  logic [SW-1:0]    r_ptr, w_ptr;
  logic             r_rd_en, w_rd_en;
  logic             r_valid, w_valid;
  logic             r_busy;
  logic             r_tmo_err, w_tmo_err;
  logic [LEN_W-1:0] r_cnt, w_cnt;
  logic [TW-1:0]    r_tcnt, w_tcnt;
  logic [GW-1:0]    r_gcnt, w_gcnt;
  logic [SW-1:0]    w_pick;
  logic             w_any;

  rr_pick #(.NREQ(NREQ), .IW(SW)) u_pick (
    .req (REQ),
    .ptr (r_ptr),
    .idx (w_pick),
    .any (w_any)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_gnt     = r_gnt;
    w_sel     = r_sel;
    w_ptr     = r_ptr;
    w_rd_en   = 1'b0;
    w_valid   = r_valid;
    w_tmo_err = 1'b0;
    w_cnt     = r_cnt;
    w_tcnt    = r_tcnt;
    w_gcnt    = r_gcnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state = ST_GRANT;
          w_sel   = w_pick;
          w_gnt   = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
          w_cnt   = LEN[w_pick*LEN_W +: LEN_W];
        end
      end
      ST_GRANT: begin
        w_valid = 1'b1;
        w_tcnt  = '0;
        w_state = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // An ack in the final allowed cycle still beats the timeout.
        if (TX_ACK) begin
          if (r_cnt != '0) begin
            w_state = ST_STREAM;
            w_rd_en = 1'b1;
          end else begin
            w_state = ST_WAIT_DONE;
            w_valid = 1'b0;
          end
        end else if (r_tcnt >= TW'(ACK_TMO - 1)) begin
          w_tmo_err = 1'b1;
          w_valid   = 1'b0;
          w_gnt     = '0;
          w_state   = ST_WAIT_DONE;
        end else begin
          w_tcnt = r_tcnt + 1'b1;
        end
      end
      ST_STREAM: begin
        if (r_cnt != '0) w_cnt = r_cnt - 1'b1;
        if (r_cnt <= LEN_W'(1)) begin
          w_state = ST_WAIT_DONE;
          w_valid = 1'b0;
        end else begin
          w_rd_en = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (FRM_STATE == FRM_IDLE) begin
          w_gnt   = '0;
          w_ptr   = SW'(wrap_inc(int'(r_sel), NREQ));
          w_gcnt  = GW'(GAP);
          w_state = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gcnt <= GW'(1)) w_state = ST_IDLE;
        else                  w_gcnt  = r_gcnt - 1'b1;
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_gnt     <= '0;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_rd_en   <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_tmo_err <= 1'b0;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_gcnt    <= '0;
    end else begin
      r_gnt     <= w_gnt;
      r_sel     <= w_sel;
      r_ptr     <= w_ptr;
      r_rd_en   <= w_rd_en;
      r_valid   <= w_valid;
      r_busy    <= (w_state != ST_IDLE);
      r_tmo_err <= w_tmo_err;
      r_cnt     <= w_cnt;
      r_tcnt    <= w_tcnt;
      r_gcnt    <= w_gcnt;
    end
  end

  assign GNT       = r_gnt;
  assign MUX_SEL   = r_sel;
  assign RD_EN     = r_rd_en;
  assign VALID     = r_valid;
  assign BUSY      = r_busy;
  assign TMO_ERR   = r_tmo_err;
  assign ARB_STATE = r_state;

endmodule

// File: tb/tb_frame_src_arbiter.sv
// Randomized frame-level bench for frame_src_arbiter against a transaction timing model.
module tb_frame_src_arbiter;

  localparam int NREQ    = 4;
  localparam int LEN_W   = 12;
  localparam int GAP     = 8;
  localparam int ACK_TMO = 64;
  localparam int SW      = $clog2(NREQ);

  logic                  CLK;
  logic                  RST;
  logic [NREQ-1:0]       REQ;
  logic [NREQ*LEN_W-1:0] LEN;
  logic [NREQ-1:0]       GNT;
  logic [SW-1:0]         MUX_SEL;
  logic                  RD_EN;
  logic                  VALID;
  logic                  TX_ACK;
  logic [3:0]            FRM_STATE;
  logic                  BUSY;
  logic                  TMO_ERR;
  logic [2:0]            ARB_STATE;

  int n_chk, n_fail, ptr_m, next_lat, rd_total, tmo_seen;

  frame_src_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W), .GAP(GAP), .ACK_TMO(ACK_TMO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ       (REQ),
    .LEN       (LEN),
    .GNT       (GNT),
    .MUX_SEL   (MUX_SEL),
    .RD_EN     (RD_EN),
    .VALID     (VALID),
    .TX_ACK    (TX_ACK),
    .FRM_STATE (FRM_STATE),
    .BUSY      (BUSY),
    .TMO_ERR   (TMO_ERR),
    .ARB_STATE (ARB_STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    if (RD_EN === 1'b1) rd_total++;
    if (TMO_ERR === 1'b1) tmo_seen++;
  endtask

  // Winner = first pending source met when walking the ring from the pointer.
  function automatic int rr_ref(input logic [NREQ-1:0] req, input int ptr);
    for (int i = 0; i < NREQ; i++)
      if (req[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    return 0;
  endfunction

  // One whole frame; ack_dly<0 means the processor never acknowledges.
  task automatic frame(input logic [NREQ-1:0] req, input int flen, input int ack_dly,
                       input int done_dly, input int rst_at, input bit scr);
    int lens[NREQ];
    int p, L, n, bad, rd0, tm0;
    logic [NREQ-1:0] oh;
    bit tmo;
    tm0 = tmo_seen;
    rd0 = rd_total;
    tmo = (ack_dly < 0);
    REQ = req;
    for (int i = 0; i < NREQ; i++) begin
      lens[i] = (flen < 0) ? int'($urandom_range(0, 6)) : flen;
      LEN[i*LEN_W +: LEN_W] = LEN_W'(lens[i]);
    end
    p  = rr_ref(req, ptr_m);
    L  = lens[p];
    oh = '0;
    oh[p] = 1'b1;

    n = 0;
    do begin
      step();
      n++;
    end while (GNT == '0 && n < 300);
    chk("grant_lat", n, next_lat);
    chk("gnt", GNT, oh);
    chk("mux_sel", MUX_SEL, p);
    chk("grant_state", ARB_STATE, 1);
    chk("grant_valid", VALID, 0);

    FRM_STATE = 4'($urandom_range(1, 15));
    if (scr) begin
      REQ = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) LEN[i*LEN_W +: LEN_W] = LEN_W'($urandom);
    end
    step();
    chk("valid_rise", VALID, 1);
    chk("busy", BUSY, 1);

    bad = 0;
    if (tmo) begin
      for (int i = 1; i <= ACK_TMO; i++) begin
        step();
        if (TMO_ERR !== (i == ACK_TMO) || VALID !== (i < ACK_TMO) || RD_EN !== 1'b0 ||
            GNT !== ((i < ACK_TMO) ? oh : '0)) bad++;
      end
      chk("tmo_shape", bad, 0);
    end else begin
      for (int i = 0; i < ack_dly; i++) begin
        step();
        if (VALID !== 1'b1 || RD_EN !== 1'b0 || TMO_ERR !== 1'b0) bad++;
      end
      chk("ack_wait", bad, 0);
      TX_ACK = 1'b1;
      rd0 = rd_total;
      for (int i = 1; i <= L + 1; i++) begin
        step();
        TX_ACK = 1'b0;
        if (RD_EN !== (i <= L) || VALID !== (i <= L) ||
            ARB_STATE !== ((i <= L) ? 3'd3 : 3'd4)) bad++;
        if (rst_at > 0 && rd_total - rd0 == rst_at) begin
          chk("pre_rst_shape", bad, 0);
          #1 RST = 1'b1;
          #1;
          chk("rst_gnt", GNT, 0);
          chk("rst_rd_en", RD_EN, 0);
          chk("rst_valid", VALID, 0);
          chk("rst_busy", BUSY, 0);
          chk("rst_state", ARB_STATE, 0);
          chk("rst_mux_sel", MUX_SEL, 0);
          REQ = '0;
          FRM_STATE = 4'b0000;
          #1 RST = 1'b0;
          ptr_m = 0;
          next_lat = 1;
          return;
        end
      end
      chk("stream_shape", bad, 0);
    end
    chk("rd_count", rd_total - rd0, tmo ? 0 : L);
    chk("done_state", ARB_STATE, 4);

    bad = 0;
    for (int i = 0; i < done_dly; i++) begin
      TX_ACK = 1'($urandom_range(0, 1));
      step();
      if (GNT !== (tmo ? '0 : oh) || RD_EN !== 1'b0 || VALID !== 1'b0 ||
          ARB_STATE !== 3'd4 || BUSY !== 1'b1) bad++;
    end
    TX_ACK = 1'b0;
    chk("done_hold", bad, 0);

    FRM_STATE = 4'b0000;
    REQ = '0;
    step();
    chk("gap_state", ARB_STATE, 5);
    chk("gap_gnt", GNT, 0);
    chk("tmo_cnt", tmo_seen - tm0, tmo ? 1 : 0);
    ptr_m = (p + 1) % NREQ;
    next_lat = GAP + 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0; rd_total = 0; tmo_seen = 0;
    RST = 1'b1; REQ = '0; LEN = '0; TX_ACK = 1'b0; FRM_STATE = 4'b0000;
    repeat (2) step();
    chk("reset_gnt", GNT, 0);
    chk("reset_valid", VALID, 0);
    chk("reset_rd_en", RD_EN, 0);
    chk("reset_busy", BUSY, 0);
    chk("reset_tmo", TMO_ERR, 0);
    chk("reset_state", ARB_STATE, 0);
    RST = 1'b0;
    ptr_m = 0;
    next_lat = 1;

    for (int k = 0; k < 5; k++) frame(4'b1111, 2, 3, 2, 0, 1'b0);
    frame(4'b0010, 5, 5, 0, 0, 1'b1);
    frame(4'b1001, 0, 2, 3, 0, 1'b1);
    frame(4'b0100, -1, -1, 4, 0, 1'b1);
    frame(4'b1111, -1, 1, 20, 0, 1'b1);
    for (int k = 0; k < 12; k++)
      frame(NREQ'($urandom_range(1, 15)), -1, int'($urandom_range(0, 10)),
            int'($urandom_range(0, 5)), 0, 1'b1);
    frame(4'b0100, 8, 2, 0, 3, 1'b0);
    frame(4'b1011, -1, 2, 1, 0, 1'b1);
    frame(4'b0001, 3, 0, 0, 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_src_arbiter.md
# frame_src_arbiter

Shares the single frame processor (VALID/TX_ACK/FRM_STATE interface) between NREQ data sources. Picks one pending source round-robin, holds VALID through the frame header, and after TX_ACK pops exactly LEN words from the granted source. It then waits for the frame processor to finish CRC/EOP and return to Idle, and enforces an inter-frame gap. Sits between the per-source readout FIFOs and the frame processor.

## Interface
- NREQ, 4 — number of requesters (2..8)
- LEN_W, 12 — width of per-source word count
- GAP, 8 — idle cycles enforced between frames (≥1)
- ACK_TMO, 64 — max cycles in Wait_Ack before timeout
- CLK  in  1  — system clock
- RST  in  1  — asynchronous, active-high reset
- REQ  in  NREQ  — source i has a complete frame pending
- LEN  in  NREQ*LEN_W  — word count of source i, slice [i*LEN_W +: LEN_W], sampled at grant
- GNT  out  NREQ  — one-hot grant; reset 0
- MUX_SEL  out  clog2(NREQ)  — index of granted source; reset 0
- RD_EN  out  1  — pop one word from granted source this cycle; reset 0
- VALID  out  1  — frame-data-valid to frame processor; reset 0
- TX_ACK  in  1  — frame processor SOF acknowledge (1-cycle)
- FRM_STATE  in  4  — frame processor state; 4'b0000 = Idle
- BUSY  out  1  — high in any state except Idle; reset 0
- TMO_ERR  out  1  — 1-cycle pulse on ack timeout; reset 0
- ARB_STATE  out  3  — current state code; reset Idle

One clock; reset is asynchronous and active-high. All outputs registered.

## Operation
- States: Idle, Grant, Wait_Ack, Stream, Wait_Done, Gap.
- Idle: if any REQ bit is set, select the first set bit at or after the pointer (wrapping), latch index into MUX_SEL, latch its LEN into the counter, set GNT, and go to Grant. If none is set, stay.
- Grant: set VALID=1 and go to Wait_Ack. LEN==0 still produces a header-only frame.
- Wait_Ack: VALID held high. On TX_ACK, go to Stream if LEN≠0, else go to Wait_Done with VALID cleared. If ACK_TMO cycles pass without TX_ACK, pulse TMO_ERR, clear VALID and GNT, and go to Wait_Done.
- Stream: RD_EN=1 and VALID=1 every cycle. The counter decrements per RD_EN. The last word cycle has both high. The next cycle both are 0 and the state is Wait_Done.
- Wait_Done: wait for FRM_STATE==4'b0000, then clear GNT, advance the pointer to (MUX_SEL+1) mod NREQ, load the gap counter, and go to Gap.
- Gap: count GAP cycles, then go to Idle.
- REQ and LEN changes after grant are ignored. TX_ACK outside Wait_Ack is ignored.
- Pointer resets to 0, so source 0 wins the first arbitration.
- RST mid-frame: all outputs return to 0 immediately and the state goes to Idle. There is no partial-frame cleanup, because the frame processor shares the same reset.

## Timing
- REQ sampled in Idle at cycle t: GNT/MUX_SEL are valid at t+1 and VALID is high at t+2.
- TX_ACK sampled high at cycle a: RD_EN/VALID are high for cycles a+1 .. a+LEN and both low at a+LEN+1.
- Each RD_EN returns data from the source in the same cycle. The frame processor sees LEN VALID cycles in Data, matching its CRC_CALC count.
- Earliest next grant after the frame processor reaches Idle is GAP+1 cycles later.
- Counter width is LEN_W. Timeout counter width is clog2(ACK_TMO+1).
- Counters saturate; they do not wrap.

## Structure
- Package frame_arb_pkg holds:
  - state codes: Idle=0, Grant=1, Wait_Ack=2, Stream=3, Wait_Done=4, Gap=5
  - FRM_IDLE = 4'b0000
- Sub-module rr_pick: combinational round-robin priority encoder with inputs req[NREQ] and ptr, and outputs idx and any.
- Top module holds the FSM, the word, gap and timeout counters, and the pointer.

## Test plan
- Single source: REQ=4'b0010 with LEN[1]=5, TX_ACK returned 5 cycles after VALID → GNT=0010, MUX_SEL=1, exactly 5 RD_EN cycles starting the cycle after TX_ACK, VALID falls with the last RD_EN.
- Round-robin: REQ=4'b1111 held, all LEN=2 → grant order 0,1,2,3,0, with ≥GAP idle cycles between GNT pulses.
- LEN=0 → VALID drops the cycle after TX_ACK, no RD_EN, FSM reaches Gap once FRM_STATE=0.
- Timeout: REQ[2]=1, TX_ACK never asserted → TMO_ERR pulses once at ACK_TMO cycles, VALID/GNT cleared, no RD_EN, next source granted after the gap.
- Wait_Done hold: FRM_STATE kept at 4'b0001 for 20 cycles after the stream ends → GNT held, no new grant until FRM_STATE=0.
- Reset mid-Stream (RST at word 3 of 8) → GNT/RD_EN/VALID/BUSY are 0 asynchronously, pointer=0, and the next REQ=4'b0001 is granted normally.
